// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between instruction fetch (IF) and data
// access (DM). The block serialises requests, runs each access for a fixed
// MEM_LAT cycles and returns a one-cycle ack together with the read data.
// The core stalls while x_req & ~x_ack.
//
// Handshake: a requester raises x_req and holds it, with its address and data
// stable, until x_ack. The ack is a one-cycle pulse. A req seen in the cycle
// after an ack is a new request. Inputs are latched at grant, so later changes
// are ignored. A req dropped before its ack still completes and still acks.
//
// Optional feature: define ARB_FAIR_EN to alternate the grant on simultaneous
// requests (the port that did not win last time wins). Without it, DM always
// beats IF.
//
// Parameters: ADDR_W (address width), DATA_W (data width),
//             MEM_LAT (access cycles, 1..15)
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   if_req/if_addr                fetch request in
//   if_ack/if_rdata               fetch ack pulse and instruction out
//   dm_req/dm_we/dm_addr/dm_wdata data request in
//   dm_ack/dm_rdata               data ack pulse and load data out
//   mem_en/mem_we/mem_addr/mem_wdata  memory control out
//   mem_rdata                     memory read data in (valid in last ACCESS cycle)
//   busy                          high in ACCESS and RESP
//   state_dbg                     current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        owner_q;
    logic        last_owner_q;
    logic        we_q;
    logic        any_req;
    logic        winner;

    assign any_req   = if_req | dm_req;
    assign state_dbg = state_q;

    // Grant decision, only used in IDLE.
    always_comb begin
        winner = OWN_IF;
`ifdef ARB_FAIR_EN
        if (if_req && dm_req) begin
            winner = ~last_owner_q;
        end else begin
            winner = dm_req ? OWN_DM : OWN_IF;
        end
`else
        // DM holds the older instruction, so it always goes first.
        winner = dm_req ? OWN_DM : OWN_IF;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decode from the state register so a reset drops them at once.
    always_comb begin
        mem_en = (state_q == S_ACCESS);
        mem_we = (state_q == S_ACCESS) && we_q;
        busy   = (state_q == S_ACCESS) || (state_q == S_RESP);
        if_ack = (state_q == S_RESP) && (owner_q == OWN_IF);
        dm_ack = (state_q == S_RESP) && (owner_q == OWN_DM);
    end

    // Grant latch, access counter and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 4'd0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            we_q         <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q      <= winner;
                        last_owner_q <= winner;
                        cnt_q        <= 4'(MEM_LAT - 1);
                        if (winner == OWN_DM) begin
                            we_q      <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            we_q      <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!we_q) begin
                        // Last access cycle: memory data is valid now.
                        if (owner_q == OWN_DM) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
